// File: rtl/uart_pkg.sv
// Shared definitions for the 16x-oversampled UART receiver: FSM states,
// oversampling constants and the three-sample majority vote.
package uart_pkg;

  localparam int OS_RATE    = 16;
  localparam int SAMPLE_MID = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_t;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; the head word is visible on rdata
// whenever empty is low, and reads as zero while the FIFO is empty.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             rxclk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // NOTE: the storage array has no reset; only the pointers are reset, and the
  // empty mask on rdata hides whatever the array powered up with.
  always_ff @(posedge rxclk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  // NOTE: clocked state is always updated with non-blocking assignments so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

endmodule

// File: rtl/uart_rx_os16.sv
// UART receiver on a 16x sample clock: majority-vote bit sampling, optional
// parity, break detection, receive FIFO and sticky error flags.
module uart_rx_os16
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       rxclk,
  input  logic       reset,
  input  logic       rx_enable,
  input  logic       rx_in,
  input  logic       rd_en,
  input  logic       clr_err,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun,
  output logic       break_det
);

  localparam logic [3:0] TICK_S0     = 4'(SAMPLE_MID);
  localparam logic [3:0] TICK_S1     = 4'(SAMPLE_MID + 1);
  localparam logic [3:0] TICK_DECIDE = 4'(SAMPLE_MID + 2);
  localparam logic [3:0] TICK_LAST   = 4'(OS_RATE - 1);
  localparam logic [2:0] LAST_BIT    = 3'(DATA_BITS - 1);
  localparam logic       PAR_EN      = (PARITY_EN != 0);
  localparam logic       PAR_ODD     = (PARITY_ODD != 0);

  rx_state_t            state, state_next;
  logic [3:0]           tick, tick_next;
  logic [2:0]           bit_cnt, bit_cnt_next;
  logic [1:0]           sync_q;
  logic                 rx_s;
  logic [1:0]           smp;
  logic                 bit_val;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit, par_bad;
  logic                 decide, last;
  logic                 frame_start, shift_en, par_cap;
  logic                 push, set_fe, set_pe, set_bd, set_ov;
  logic                 fifo_full, fifo_empty;
  logic [DATA_BITS-1:0] fifo_rdata;

  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], rx_in};
  end
  assign rx_s = sync_q[1];

  assign decide  = (tick == TICK_DECIDE);
  assign last    = (tick == TICK_LAST);
  assign bit_val = majority3(smp[0], smp[1], rx_s);

  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      tick    <= '0;
      bit_cnt <= '0;
    end else begin
      state   <= state_next;
      tick    <= tick_next;
      bit_cnt <= bit_cnt_next;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through the
  // case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_next   = state;
    tick_next    = tick + 4'd1;
    bit_cnt_next = bit_cnt;
    frame_start  = 1'b0;
    shift_en     = 1'b0;
    par_cap      = 1'b0;
    push         = 1'b0;
    set_fe       = 1'b0;
    set_pe       = 1'b0;
    set_bd       = 1'b0;
    if (!rx_enable) begin
      state_next = ST_IDLE;
      tick_next  = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          tick_next = '0;
          if (!rx_s) begin
            state_next  = ST_START;
            frame_start = 1'b1;
          end
        end
        ST_START: begin
          if (decide && bit_val) begin
            state_next = ST_IDLE;
          end else if (last) begin
            state_next   = ST_DATA;
            bit_cnt_next = '0;
          end
        end
        ST_DATA: begin
          shift_en = decide;
          if (last) begin
            if (bit_cnt == LAST_BIT) state_next = PAR_EN ? ST_PARITY : ST_STOP;
            else                     bit_cnt_next = bit_cnt + 3'd1;
          end
        end
        ST_PARITY: begin
          par_cap = decide;
          if (last) state_next = ST_STOP;
        end
        ST_STOP: begin
          // Stop decision is final at mid-bit; return without finishing the bit.
          if (decide) begin
            if (bit_val) begin
              push       = 1'b1;
              set_pe     = par_bad;
              state_next = ST_IDLE;
            end else if (shreg == '0 && !(PAR_EN && par_bit)) begin
              set_bd     = 1'b1;
              state_next = ST_BREAK;
            end else begin
              set_fe     = 1'b1;
              state_next = ST_IDLE;
            end
          end
        end
        ST_BREAK: begin
          tick_next = '0;
          if (rx_s) state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      smp     <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      par_bad <= 1'b0;
    end else begin
      if (tick == TICK_S0) smp[0] <= rx_s;
      if (tick == TICK_S1) smp[1] <= rx_s;
      if (frame_start) begin
        par_bit <= 1'b0;
        par_bad <= 1'b0;
      end
      if (shift_en) shreg <= {bit_val, shreg[DATA_BITS-1:1]};
      if (par_cap) begin
        par_bit <= bit_val;
        par_bad <= ((^shreg) ^ bit_val) != PAR_ODD;
      end
    end
  end

  // A pop in the same cycle frees the slot, so only an unpaired push overruns.
  assign set_ov = push && fifo_full && !(rd_en && rx_valid);

  always_ff @(posedge rxclk or posedge reset) begin
    if (reset) begin
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
      break_det  <= 1'b0;
    end else begin
      frame_err  <= set_fe | (frame_err  & ~clr_err);
      parity_err <= set_pe | (parity_err & ~clr_err);
      overrun    <= set_ov | (overrun    & ~clr_err);
      break_det  <= set_bd | (break_det  & ~clr_err);
    end
  end

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .rxclk (rxclk),
    .reset (reset),
    .push  (push),
    .pop   (rd_en),
    .wdata (shreg),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign rx_valid = !fifo_empty;
  assign rx_data  = 8'(fifo_rdata);

endmodule

// File: tb/tb_uart_rx_os16.sv
// Scoreboard bench for uart_rx_os16: unit 0 is 8N1, unit 1 is 8E1, both with a
// four-entry FIFO; frames are modelled at the frame level and words checked on pop.
module tb_uart_rx_os16;
  import uart_pkg::*;

  localparam int DEPTH = 4;
  localparam int BIT_T = 16;

  logic       rxclk = 1'b0;
  logic       reset;
  logic [1:0] rx_enable_v, rx_in_v, rd_en_v, clr_err_v;
  logic [7:0] rx_data_v [2];
  logic [1:0] rx_valid_v, frame_err_v, parity_err_v, overrun_v, break_det_v;

  int checks = 0;
  int errors = 0;
  int pops_seen [2];
  logic [7:0] exp_q0 [$];
  logic [7:0] exp_q1 [$];
  bit [3:0] exp_flags [2];  // {break_det, overrun, parity_err, frame_err}

  always #5 rxclk = ~rxclk;

  uart_rx_os16 #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .FIFO_DEPTH(DEPTH)) dut_a (
    .rxclk(rxclk), .reset(reset), .rx_enable(rx_enable_v[0]), .rx_in(rx_in_v[0]),
    .rd_en(rd_en_v[0]), .clr_err(clr_err_v[0]), .rx_data(rx_data_v[0]),
    .rx_valid(rx_valid_v[0]), .frame_err(frame_err_v[0]), .parity_err(parity_err_v[0]),
    .overrun(overrun_v[0]), .break_det(break_det_v[0]));

  uart_rx_os16 #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .FIFO_DEPTH(DEPTH)) dut_b (
    .rxclk(rxclk), .reset(reset), .rx_enable(rx_enable_v[1]), .rx_in(rx_in_v[1]),
    .rd_en(rd_en_v[1]), .clr_err(clr_err_v[1]), .rx_data(rx_data_v[1]),
    .rx_valid(rx_valid_v[1]), .frame_err(frame_err_v[1]), .parity_err(parity_err_v[1]),
    .overrun(overrun_v[1]), .break_det(break_det_v[1]));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: every accepted pop is compared with the head of that unit's queue.
  always @(negedge rxclk) begin
    for (int u = 0; u < 2; u++) begin
      if (rd_en_v[u] && rx_valid_v[u]) begin
        pops_seen[u]++;
        if ((u == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
          checks++;
          errors++;
          $display("FAIL unit%0d_unexpected_word: got %0h expected none", u, rx_data_v[u]);
        end else if (u == 0) begin
          check("unit0_pop_word", 32'(rx_data_v[0]), 32'(exp_q0.pop_front()));
        end else begin
          check("unit1_pop_word", 32'(rx_data_v[1]), 32'(exp_q1.pop_front()));
        end
      end
    end
  end

  task automatic check_status(input int u, input string tag);
    @(negedge rxclk);
    check({tag, "_flags"},
          32'({break_det_v[u], overrun_v[u], parity_err_v[u], frame_err_v[u]}),
          32'(exp_flags[u]));
    check({tag, "_valid"}, 32'(rx_valid_v[u]),
          32'((u == 0 ? exp_q0.size() : exp_q1.size()) != 0));
  endtask

  task automatic clear_flags(input int u);
    @(posedge rxclk); #1;
    clr_err_v[u] = 1'b1;
    @(posedge rxclk); #1;
    clr_err_v[u] = 1'b0;
    exp_flags[u] = '0;
  endtask

  task automatic drain(input int u, input string tag);
    int want;
    int start;
    want  = (u == 0) ? exp_q0.size() : exp_q1.size();
    start = pops_seen[u];
    for (int i = 0; i < DEPTH + 2; i++) begin
      @(posedge rxclk); #1;
      if (!rx_valid_v[u]) break;
      rd_en_v[u] = 1'b1;
      @(posedge rxclk); #1;
      rd_en_v[u] = 1'b0;
    end
    check({tag, "_drain_count"}, 32'(pops_seen[u] - start), 32'(want));
    check({tag, "_valid_after_drain"}, 32'(rx_valid_v[u]), 32'd0);
  endtask

  // Frame-level reference model, then the line waveform: start, data LSB first,
  // parity on unit 1, stop, then idle gap. pop_at_push pulses rd_en in the
  // stop-bit decision cycle (2 sync + 1 detect + 9 ticks into the stop bit).
  task automatic send_frame(input int u, input logic [7:0] data, input bit stop_bit,
                            input bit flip_par, input int gap_bits,
                            input bit pop_at_push, input bit aborted);
    bit par_en;
    bit par_bit;
    bit line_q [$];
    int held;
    par_en  = (u == 1);
    par_bit = (^data) ^ flip_par;
    if (!aborted) begin
      if (stop_bit) begin
        held = ((u == 0) ? exp_q0.size() : exp_q1.size()) - (pop_at_push ? 1 : 0);
        if (held >= DEPTH)  exp_flags[u][2] = 1'b1;
        else if (u == 0)    exp_q0.push_back(data);
        else                exp_q1.push_back(data);
        if (par_en && flip_par) exp_flags[u][1] = 1'b1;
      end else if (data == 8'h00 && !(par_en && par_bit)) begin
        exp_flags[u][3] = 1'b1;
      end else begin
        exp_flags[u][0] = 1'b1;
      end
    end
    line_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) line_q.push_back(data[i]);
    if (par_en) line_q.push_back(par_bit);
    line_q.push_back(stop_bit);
    @(posedge rxclk); #1;
    fork
      begin
        foreach (line_q[i]) begin
          rx_in_v[u] = line_q[i];
          repeat (BIT_T) @(posedge rxclk);
          #1;
        end
        rx_in_v[u] = 1'b1;
        repeat (BIT_T * gap_bits) @(posedge rxclk);
        #1;
      end
      begin
        if (pop_at_push) begin
          repeat (12 + BIT_T * (line_q.size() - 1)) @(posedge rxclk);
          #1;
          rd_en_v[u] = 1'b1;
          @(posedge rxclk); #1;
          rd_en_v[u] = 1'b0;
        end
      end
    join
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int u;
    logic [7:0] d;
    bit stop;
    bit flip;
    reset       = 1'b1;
    rx_in_v     = 2'b11;
    rx_enable_v = 2'b11;
    rd_en_v     = 2'b00;
    clr_err_v   = 2'b00;
    pops_seen[0] = 0;
    pops_seen[1] = 0;
    exp_flags[0] = '0;
    exp_flags[1] = '0;

    repeat (3) @(negedge rxclk);
    for (int k = 0; k < 2; k++) begin
      check("reset_rx_data", 32'(rx_data_v[k]), 32'd0);
      check("reset_status", 32'({rx_valid_v[k], break_det_v[k], overrun_v[k],
                                 parity_err_v[k], frame_err_v[k]}), 32'd0);
    end
    @(posedge rxclk); #1;
    reset = 1'b0;
    repeat (20) @(posedge rxclk);

    // 8N1 0xA5
    send_frame(0, 8'hA5, 1'b1, 1'b0, 2, 1'b0, 1'b0);
    check_status(0, "a5");
    check("a5_head", 32'(rx_data_v[0]), 32'hA5);
    drain(0, "a5");

    // Even parity, 0x03 with wrong parity bit
    send_frame(1, 8'h03, 1'b1, 1'b1, 2, 1'b0, 1'b0);
    check_status(1, "parity");
    check("parity_head", 32'(rx_data_v[1]), 32'h03);
    clear_flags(1);
    check_status(1, "parity_clr");
    drain(1, "parity");

    // Six-tick glitch is a false start
    @(posedge rxclk); #1;
    rx_in_v[0] = 1'b0;
    repeat (6) @(posedge rxclk);
    #1;
    rx_in_v[0] = 1'b1;
    repeat (40) @(posedge rxclk);
    check_status(0, "glitch");

    // Five frames into a four-deep FIFO
    for (int i = 1; i <= 5; i++) send_frame(0, 8'(i), 1'b1, 1'b0, 2, 1'b0, 1'b0);
    check_status(0, "overrun");
    drain(0, "overrun");
    clear_flags(0);

    // Full FIFO with a pop in the push cycle: no overrun
    for (int i = 0; i < 4; i++) send_frame(0, 8'h21 + 8'(i), 1'b1, 1'b0, 2, 1'b0, 1'b0);
    send_frame(0, 8'h25, 1'b1, 1'b0, 2, 1'b1, 1'b0);
    check_status(0, "push_pop_full");
    drain(0, "push_pop_full");

    // Line low for 12 bit times: break
    @(posedge rxclk); #1;
    rx_in_v[0] = 1'b0;
    repeat (12 * BIT_T) @(posedge rxclk);
    #1;
    check("break_state_low", 32'(dut_a.state), 32'(ST_BREAK));
    exp_flags[0][3] = 1'b1;
    rx_in_v[0] = 1'b1;
    repeat (2 * BIT_T) @(posedge rxclk);
    #1;
    check("break_state_released", 32'(dut_a.state), 32'(ST_IDLE));
    check_status(0, "break");
    clear_flags(0);
    send_frame(0, 8'h55, 1'b1, 1'b0, 2, 1'b0, 1'b0);
    check_status(0, "after_break");
    drain(0, "after_break");

    // Framing error
    send_frame(0, 8'h5A, 1'b0, 1'b0, 3, 1'b0, 1'b0);
    check_status(0, "frame_err");
    clear_flags(0);

    // Disable mid-frame: partial frame dropped, FIFO content kept
    send_frame(0, 8'h66, 1'b1, 1'b0, 2, 1'b0, 1'b0);
    fork
      send_frame(0, 8'h33, 1'b1, 1'b0, 3, 1'b0, 1'b1);
      begin
        repeat (BIT_T * 3 + 8) @(posedge rxclk);
        #1;
        rx_enable_v[0] = 1'b0;
      end
    join
    rx_enable_v[0] = 1'b1;
    repeat (BIT_T) @(posedge rxclk);
    check_status(0, "disable");
    drain(0, "disable");

    // Randomized traffic on both units
    for (int n = 0; n < 40; n++) begin
      u    = int'($urandom_range(0, 1));
      d    = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      stop = ($urandom_range(0, 7) != 0);
      flip = (u == 1) && ($urandom_range(0, 3) == 0);
      send_frame(u, d, stop, flip, int'($urandom_range(2, 4)), 1'b0, 1'b0);
      if ($urandom_range(0, 2) == 0) drain(u, "rnd");
      if (n % 8 == 7) begin
        check_status(0, "rnd_a");
        check_status(1, "rnd_b");
        clear_flags(0);
        clear_flags(1);
      end
    end
    drain(0, "rnd_end_a");
    drain(1, "rnd_end_b");
    clear_flags(0);
    clear_flags(1);

    // Reset at data bit 4 of 0x3C with a word queued and a flag set
    send_frame(0, 8'h11, 1'b1, 1'b0, 2, 1'b0, 1'b0);
    send_frame(0, 8'h5A, 1'b0, 1'b0, 3, 1'b0, 1'b0);
    fork
      send_frame(0, 8'h3C, 1'b1, 1'b0, 3, 1'b0, 1'b1);
      begin
        repeat (BIT_T * 5 + 8) @(posedge rxclk);
        #1;
        reset = 1'b1;
      end
    join
    exp_q0.delete();
    exp_q1.delete();
    exp_flags[0] = '0;
    exp_flags[1] = '0;
    @(negedge rxclk);
    check("midreset_rx_data", 32'(rx_data_v[0]), 32'd0);
    check_status(0, "midreset");
    @(posedge rxclk); #1;
    reset = 1'b0;
    repeat (BIT_T) @(posedge rxclk);
    send_frame(0, 8'h7E, 1'b1, 1'b0, 2, 1'b0, 1'b0);
    check_status(0, "after_reset");
    check("after_reset_head", 32'(rx_data_v[0]), 32'h7E);
    drain(0, "after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
